dct_skew_feeder: RTL and testbench

- Upstream feeder for the DCT systolic array of PE cells in the JPEG encoder.
- Accepts a serial pixel stream with a valid/ready handshake and assembles vectors of N samples, one column of the 8x8 block.
- Level-shifts each sample to signed and injects the vector into the array diagonally skewed: lane k is delayed k cycles.
- Drains the array after the last sample of a block, with back-pressure toward the pixel source.

---
 rtl/dct_skew_feeder_pkg.sv | 23 ++
 rtl/dct_skew_feeder_if.sv | 14 +
 rtl/dct_skew_feeder_skew_delay_line.sv | 34 +++
 rtl/dct_skew_feeder.sv | 114 +++++++++++
 tb/tb_dct_skew_feeder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dct_skew_feeder_pkg.sv
// Shared types, default sizes and the sample level-shift helper for the DCT skew feeder.
// Build option: define DCT_LEVEL_SHIFT_EN to convert unsigned pixels to signed (MSB inversion).
package dct_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } dct_state_e;

  localparam int DCT_N           = 8;
  localparam int DCT_Y_WIDTH     = 8;
  localparam int DCT_VEC_PER_BLK = 8;

  // Returns the stored form of a width-bit sample held in the low bits of pix.
  function automatic logic [31:0] level_shift(input logic [31:0] pix, input int width);
`ifdef DCT_LEVEL_SHIFT_EN
    return (pix & ({32{1'b1}} >> (32 - width))) ^ (32'd1 << (width - 1));
`else
    return pix & ({32{1'b1}} >> (32 - width));
`endif
  endfunction

endpackage

// File: rtl/dct_skew_feeder_if.sv
// Pixel stream into the DCT skew feeder.
// A beat transfers on a rising clock edge where in_valid && in_ready are both high;
// the source holds in_pix/in_last stable while in_valid is high and in_ready is low.
interface dct_skew_feeder_if #(
  parameter int Y_WIDTH = dct_pkg::DCT_Y_WIDTH
) ();
  logic               in_valid;
  logic               in_ready;
  logic [Y_WIDTH-1:0] in_pix;
  logic               in_last;

  modport master (output in_valid, output in_pix, output in_last, input in_ready);
  modport slave  (input in_valid, input in_pix, input in_last, output in_ready);
endinterface

// File: rtl/dct_skew_feeder_skew_delay_line.sv
// Fixed-latency delay of DEPTH+1 registers carrying a sample and its valid; data is zero when invalid.
module skew_delay_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [DEPTH:0]   v_q;
  logic [WIDTH-1:0] d_q [DEPTH+1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= '0;
      for (int i = 0; i <= DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid_i;
      d_q[0] <= in_valid_i ? in_data_i : '0;
      for (int i = 1; i <= DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid_o = v_q[DEPTH];
  assign out_data_o  = d_q[DEPTH];

endmodule

// File: rtl/dct_skew_feeder.sv
// Assembles pixel vectors and injects them diagonally skewed into the DCT systolic array.
// Build option: DCT_LEVEL_SHIFT_EN selects unsigned-to-signed conversion of each sample.
module dct_skew_feeder
  import dct_pkg::*;
#(
  parameter int N           = DCT_N,
  parameter int Y_WIDTH     = DCT_Y_WIDTH,
  parameter int VEC_PER_BLK = DCT_VEC_PER_BLK
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dct_skew_feeder_if.slave     pix_if,
  output logic [N*Y_WIDTH-1:0] out_y_o,
  output logic [N-1:0]         out_valid_o,
  output logic                 blk_done_o,
  output dct_state_e           state_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = (VEC_PER_BLK > 1) ? $clog2(VEC_PER_BLK) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [IW-1:0] FCNT_LAST = IW'((N > 1) ? N - 2 : 0);
  localparam logic [VW-1:0] VCNT_LAST = VW'(VEC_PER_BLK - 1);

  dct_state_e         state_q, state_d;
  logic [IW-1:0]      idx_q, fcnt_q;
  logic [VW-1:0]      vcnt_q;
  logic [Y_WIDTH-1:0] vec_q    [N];
  logic [Y_WIDTH-1:0] launch_d [N];
  logic [Y_WIDTH-1:0] lane_d   [N];
  logic [Y_WIDTH-1:0] sample;
  logic               in_ready, xfer, vec_done, blk_end, done_d, blk_done_q;

  assign sample   = Y_WIDTH'(level_shift(32'(pix_if.in_pix), Y_WIDTH));
  assign xfer     = pix_if.in_valid && in_ready;
  assign vec_done = xfer && ((idx_q == IDX_LAST) || pix_if.in_last);
  // A block ends on an explicit last or on the final vector of the block, whichever comes first.
  assign blk_end  = vec_done && (pix_if.in_last || (vcnt_q == VCNT_LAST));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      vcnt_q <= '0;
      for (int k = 0; k < N; k++) vec_q[k] <= '0;
    end else if (xfer) begin
      vec_q[idx_q] <= sample;
      if (blk_end) begin
        idx_q  <= '0;
        vcnt_q <= '0;
      end else if (vec_done) begin
        idx_q  <= '0;
        vcnt_q <= vcnt_q + 1'b1;
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  // Completing vector: stored lanes below idx, the current sample at idx, zero padding above.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      launch_d[k] = '0;
      if (k < int'(idx_q))       launch_d[k] = vec_q[k];
      else if (k == int'(idx_q)) launch_d[k] = sample;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH (k),
      .WIDTH (Y_WIDTH)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (vec_done),
      .in_data_i   (launch_d[k]),
      .out_valid_o (out_valid_o[k]),
      .out_data_o  (lane_d[k])
    );
    assign out_y_o[k*Y_WIDTH +: Y_WIDTH] = lane_d[k];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FILL;
      fcnt_q     <= '0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= (state_q == FLUSH) ? fcnt_q + 1'b1 : '0;
      blk_done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (blk_end && (N > 1)) state_d = FLUSH;
      FLUSH:   if (fcnt_q == FCNT_LAST) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // The done pulse is registered so it lands with lane N-1 of the final vector.
  always_comb begin
    in_ready = (state_q == FILL) && !rst_i;
    done_d   = (N == 1) ? blk_end : ((state_q == FLUSH) && (fcnt_q == FCNT_LAST));
  end

  assign pix_if.in_ready = in_ready;
  assign blk_done_o      = blk_done_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_dct_skew_feeder.sv
// Self-checking bench for dct_skew_feeder: directed and random pixel streams versus a cycle schedule model.
module tb_dct_skew_feeder;
  import dct_pkg::*;

  localparam int N    = 8;
  localparam int YW   = 8;
  localparam int VPB  = 8;
  localparam int MAXC = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*YW-1:0] out_y;
  logic [N-1:0]    out_valid;
  logic            blk_done;
  dct_state_e      state;

  dct_skew_feeder_if #(.Y_WIDTH(YW)) pix_if ();

  dct_skew_feeder #(.N(N), .Y_WIDTH(YW), .VEC_PER_BLK(VPB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pix_if      (pix_if),
    .out_y_o     (out_y),
    .out_valid_o (out_valid),
    .blk_done_o  (blk_done),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  // Expected output schedule indexed by bench cycle number.
  logic          exp_v    [MAXC][N];
  logic [YW-1:0] exp_d    [MAXC][N];
  logic          exp_done [MAXC];

  logic [YW-1:0] m_vec[$];
  int            m_vcnt;
  int            blocked_until;
  int            cyc;
  int            n_checks;
  int            n_errors;
  bit            chk_en;

  function automatic logic [YW-1:0] ref_shift(input logic [YW-1:0] p);
`ifdef DCT_LEVEL_SHIFT_EN
    return YW'(int'(p) - 128);
`else
    return p;
`endif
  endfunction

  task automatic wipe_after(input int c);
    for (int i = c + 1; i < MAXC; i++) begin
      exp_done[i] = 1'b0;
      for (int k = 0; k < N; k++) begin
        exp_v[i][k] = 1'b0;
        exp_d[i][k] = '0;
      end
    end
  endtask

  task automatic model_xfer(input logic [YW-1:0] p, input logic l);
    m_vec.push_back(p);
    if (m_vec.size() == N || l) begin
      if (cyc + N + 1 >= MAXC) begin
        $display("FAIL schedule_overflow cyc=%0d limit=%0d", cyc, MAXC);
        $fatal(1, "schedule overflow");
      end
      for (int k = 0; k < N; k++) begin
        exp_v[cyc+1+k][k] = 1'b1;
        exp_d[cyc+1+k][k] = (k < m_vec.size()) ? ref_shift(m_vec[k]) : '0;
      end
      m_vcnt++;
      if (l || m_vcnt == VPB) begin
        blocked_until = cyc + N - 1;
        exp_done[cyc+N] = 1'b1;
        m_vcnt = 0;
      end
      m_vec.delete();
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [YW-1:0] p, input logic l);
    logic            exp_ready;
    logic [N-1:0]    ev;
    logic [N*YW-1:0] ey;
    dct_state_e      exp_st;
    rst             = r;
    pix_if.in_valid = v;
    pix_if.in_pix   = p;
    pix_if.in_last  = l;
    exp_ready = !r && (cyc > blocked_until);
    exp_st    = (cyc <= blocked_until) ? FLUSH : FILL;
    for (int k = 0; k < N; k++) begin
      ev[k]          = exp_v[cyc][k];
      ey[k*YW +: YW] = exp_d[cyc][k];
    end
    @(negedge clk);
    n_checks++;
    assert (pix_if.in_ready === exp_ready) else begin
      n_errors++;
      $error("FAIL in_ready cyc=%0d obs=%b exp=%b", cyc, pix_if.in_ready, exp_ready);
    end
    if (chk_en) begin
      n_checks++;
      assert (out_valid === ev) else begin
        n_errors++;
        $error("FAIL out_valid cyc=%0d obs=%b exp=%b", cyc, out_valid, ev);
      end
      n_checks++;
      assert (out_y === ey) else begin
        n_errors++;
        $error("FAIL out_y cyc=%0d obs=%h exp=%h", cyc, out_y, ey);
      end
      n_checks++;
      assert (blk_done === exp_done[cyc]) else begin
        n_errors++;
        $error("FAIL blk_done cyc=%0d obs=%b exp=%b", cyc, blk_done, exp_done[cyc]);
      end
      if (!r) begin
        n_checks++;
        assert (state === exp_st) else begin
          n_errors++;
          $error("FAIL state cyc=%0d obs=%0d exp=%0d", cyc, state, exp_st);
        end
      end
    end
    if (r) begin
      wipe_after(cyc);
      m_vec.delete();
      m_vcnt        = 0;
      blocked_until = cyc;
    end else if (v && exp_ready) begin
      model_xfer(p, l);
    end
    @(posedge clk);
    #1;
    if (r) chk_en = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom()), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    pix_if.in_valid = 1'b0;
    pix_if.in_pix   = '0;
    pix_if.in_last  = 1'b0;
    cyc             = 0;
    n_checks        = 0;
    n_errors        = 0;
    chk_en          = 1'b0;
    m_vcnt          = 0;
    blocked_until   = -1;
    wipe_after(-1);
    @(posedge clk);
    #1;

    do_reset();
    do_reset();

    // Pixels 0..7 back to back.
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    idle(10);

    // Full 64-pixel block of constant 200 with last on the final pixel.
    do_reset();
    for (int i = 0; i < N * VPB; i++) step(1'b0, 1'b1, 8'd200, (i == N * VPB - 1));
    idle(12);

    // Short vector: last on the third sample.
    do_reset();
    step(1'b0, 1'b1, 8'd10, 1'b0);
    step(1'b0, 1'b1, 8'd20, 1'b0);
    step(1'b0, 1'b1, 8'd30, 1'b1);
    idle(10);

    // Reset while lane 4 of the final vector is emitting: no done pulse may follow.
    do_reset();
    step(1'b0, 1'b1, 8'd1, 1'b0);
    step(1'b0, 1'b1, 8'd2, 1'b0);
    step(1'b0, 1'b1, 8'd3, 1'b1);
    idle(4);
    do_reset();
    idle(10);

    // Alternating valid across one vector.
    do_reset();
    for (int i = 0; i < 2 * N; i++) step(1'b0, (i % 2 == 0), 8'($urandom()), 1'b0);
    idle(10);

    // Single pixel 0x05 ending a block.
    do_reset();
    step(1'b0, 1'b1, 8'h05, 1'b1);
    idle(10);

    // Random traffic with occasional early last.
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'b0, ($urandom_range(0, 9) < 7), 8'($urandom()), ($urandom_range(0, 19) == 0));
    idle(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
